fpu_wb_bridge: RTL and testbench

//  Wishbone-classic slave bridge between the Caravel user-project bus and the FPU register file.

---
 rtl/fpu_wb_bridge_if.sv | 19 +
 rtl/fpu_wb_bridge.sv | 94 +++++++++
 tb/tb_fpu_wb_bridge.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fpu_wb_bridge_if.sv
// fpu_wb_bridge_if: Wishbone-classic bus signals between the Caravel master and the FPU bridge
interface fpu_wb_bridge_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/fpu_wb_bridge.sv
// fpu_wb_bridge: Wishbone slave to FPU register-file strobes, with read-modify-write for partial writes
module fpu_wb_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_SPAN = 32'h0000_0030,
    parameter logic [31:0] IDLE_ADDR = 32'h3000_00FC
) (
    input  logic                clk,
    input  logic                rst_l,
    fpu_wb_bridge_if.slave      wb,
    output logic [31:0]         reg_addr,
    output logic                reg_wren,
    output logic [31:0]         reg_wrdata,
    input  logic [31:0]         reg_rddata
);
    typedef enum logic [2:0] {IDLE, READ, MERGE_RD, WRITE, ACK} state_t;
    state_t      state;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;
    logic [31:0] adr_w;
    logic [31:0] mask;
    logic [31:0] merged;
    logic        req;
    logic        hit;
    always_comb begin
        adr_w  = {wb.wbs_adr_i[31:2], 2'b00};
        req    = wb.wbs_cyc_i & wb.wbs_stb_i;
        hit    = (adr_w >= BASE_ADDR) && (adr_w < BASE_ADDR + ADDR_SPAN);
        mask   = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
        merged = (dat_q & mask) | (reg_rddata & ~mask);
    end
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= IDLE;
            wb.wbs_ack_o  <= 1'b0;
            wb.wbs_dat_o  <= '0;
            reg_addr      <= IDLE_ADDR;
            reg_wren      <= 1'b0;
            reg_wrdata    <= '0;
            sel_q         <= '0;
            dat_q         <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    sel_q <= wb.wbs_sel_i;
                    dat_q <= wb.wbs_dat_i;
                    // Misses and empty byte-enable writes complete without touching the register file
                    if (!hit || (wb.wbs_we_i && wb.wbs_sel_i == 4'h0)) begin
                        state        <= ACK;
                        wb.wbs_ack_o <= 1'b1;
                        wb.wbs_dat_o <= '0;
                    end else begin
                        reg_addr <= adr_w;
                        if (!wb.wbs_we_i) begin
                            state <= READ;
                        end else if (wb.wbs_sel_i == 4'hF) begin
                            state      <= WRITE;
                            reg_wren   <= 1'b1;
                            reg_wrdata <= wb.wbs_dat_i;
                        end else begin
                            state <= MERGE_RD;
                        end
                    end
                end
                READ: begin
                    reg_addr     <= IDLE_ADDR;
                    state        <= wb.wbs_cyc_i ? ACK : IDLE;
                    wb.wbs_ack_o <= wb.wbs_cyc_i;
                    wb.wbs_dat_o <= wb.wbs_cyc_i ? reg_rddata : '0;
                end
                MERGE_RD: if (wb.wbs_cyc_i) begin
                    state      <= WRITE;
                    reg_wren   <= 1'b1;
                    reg_wrdata <= merged;
                end else begin
                    state    <= IDLE;
                    reg_addr <= IDLE_ADDR;
                end
                WRITE: begin
                    reg_wren     <= 1'b0;
                    reg_addr     <= IDLE_ADDR;
                    state        <= wb.wbs_cyc_i ? ACK : IDLE;
                    wb.wbs_ack_o <= wb.wbs_cyc_i;
                    wb.wbs_dat_o <= '0;
                end
                ACK: begin
                    state        <= IDLE;
                    wb.wbs_ack_o <= 1'b0;
                    wb.wbs_dat_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_wb_bridge.sv
// tb_fpu_wb_bridge: scoreboard bench for fpu_wb_bridge with a small register-file model
module tb_fpu_wb_bridge;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] SPAN = 32'h0000_0030;
    localparam logic [31:0] IDLE_A = 32'h3000_00FC;
    typedef struct {logic [31:0] data; int c0; int lat;} exp_t;
    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic [31:0] reg_addr;
    logic        reg_wren;
    logic [31:0] reg_wrdata;
    logic [31:0] reg_rddata;
    logic [31:0] mem [16];
    logic        seeded = 1'b0;
    logic [3:0]  ridx;
    int          cyc_cnt = 0;
    int          wr_cnt = 0;
    int          ack_cnt = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        sb [$];
    logic [31:0] tr_addr [2048];
    logic        tr_wren [2048];
    logic [31:0] tr_wdata [2048];
    fpu_wb_bridge_if wb ();
    fpu_wb_bridge dut (
        .clk(clk), .rst_l(rst_l), .wb(wb),
        .reg_addr(reg_addr), .reg_wren(reg_wren), .reg_wrdata(reg_wrdata), .reg_rddata(reg_rddata)
    );
    always #5 clk = ~clk;
    assign ridx = reg_addr[5:2];
    assign reg_rddata = (reg_addr >= BASE && reg_addr < BASE + SPAN) ? mem[ridx] : '0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!seeded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
            mem[1] <= 32'h1122_3344;
            mem[5] <= 32'h0000_0001;
            seeded <= 1'b1;
        end else if (reg_wren) begin
            mem[ridx] <= reg_wrdata;
            wr_cnt <= wr_cnt + 1;
        end
    end
    always @(negedge clk) begin
        tr_addr[cyc_cnt % 2048]  <= reg_addr;
        tr_wren[cyc_cnt % 2048]  <= reg_wren;
        tr_wdata[cyc_cnt % 2048] <= reg_wrdata;
        if (wb.wbs_ack_o) begin
            ack_cnt <= ack_cnt + 1;
            if (sb.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_data", wb.wbs_dat_o, e.data);
                chk("ack_latency", cyc_cnt - e.c0, e.lat);
            end
        end
    end
    task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [31:0] exp_d, input int lat, output int c0);
        int n;
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_sel_i = sel; wb.wbs_adr_i = adr; wb.wbs_dat_i = dat;
        c0 = cyc_cnt;
        sb.push_back('{exp_d, c0, lat});
        n = 0;
        do begin @(negedge clk); n++; end while (!wb.wbs_ack_o && n < 10);
        if (!wb.wbs_ack_o) begin
            chk("ack_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        #1;
    endtask
    task automatic start(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_sel_i = sel; wb.wbs_adr_i = adr; wb.wbs_dat_i = dat;
    endtask
    initial begin
        int c0, w0, a0;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = '0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
        chk("rst_dat", wb.wbs_dat_o, 32'd0);
        chk("rst_addr", reg_addr, IDLE_A);
        chk("rst_wren", {31'd0, reg_wren}, 32'd0);
        chk("rst_wdata", reg_wrdata, 32'd0);
        rst_l = 1'b1;
        xfer(1'b1, 4'hF, 32'h3000_0000, 32'h3F80_0000, 32'd0, 2, c0);
        chk("fw_addr_n", tr_addr[c0], IDLE_A);
        chk("fw_wren", {31'd0, tr_wren[c0+1]}, 32'd1);
        chk("fw_addr", tr_addr[c0+1], 32'h3000_0000);
        chk("fw_wdata", tr_wdata[c0+1], 32'h3F80_0000);
        chk("fw_wren_after", {31'd0, tr_wren[c0+2]}, 32'd0);
        chk("fw_mem", mem[0], 32'h3F80_0000);
        xfer(1'b0, 4'hF, 32'h3000_0014, 32'd0, 32'h0000_0001, 2, c0);
        chk("rd_addr_n", tr_addr[c0], IDLE_A);
        chk("rd_addr", tr_addr[c0+1], 32'h3000_0014);
        chk("rd_addr_n2", tr_addr[c0+2], IDLE_A);
        chk("rd_wren", {31'd0, tr_wren[c0+1]}, 32'd0);
        w0 = wr_cnt;
        xfer(1'b1, 4'h3, 32'h3000_0004, 32'hAABB_CCDD, 32'd0, 3, c0);
        chk("pw_rd_addr", tr_addr[c0+1], 32'h3000_0004);
        chk("pw_rd_wren", {31'd0, tr_wren[c0+1]}, 32'd0);
        chk("pw_wr_wren", {31'd0, tr_wren[c0+2]}, 32'd1);
        chk("pw_wr_data", tr_wdata[c0+2], 32'h1122_CCDD);
        chk("pw_mem", mem[1], 32'h1122_CCDD);
        chk("pw_wr_cnt", wr_cnt - w0, 32'd1);
        w0 = wr_cnt;
        xfer(1'b0, 4'hF, 32'h3000_0100, 32'd0, 32'd0, 1, c0);
        chk("oow_addr0", tr_addr[c0], IDLE_A);
        chk("oow_addr1", tr_addr[c0+1], IDLE_A);
        xfer(1'b1, 4'hF, 32'h3000_0030, 32'h1234_5678, 32'd0, 1, c0);
        xfer(1'b0, 4'hF, 32'h2FFF_FFFC, 32'd0, 32'd0, 1, c0);
        xfer(1'b1, 4'h0, 32'h3000_0008, 32'hDEAD_BEEF, 32'd0, 1, c0);
        chk("nowrite_cnt", wr_cnt - w0, 32'd0);
        chk("sel0_mem", mem[2], 32'hA000_0002);
        xfer(1'b0, 4'hF, 32'h3000_002C, 32'd0, 32'hA000_000B, 2, c0);
        xfer(1'b0, 4'hF, 32'h3000_0017, 32'd0, 32'h0000_0001, 2, c0);
        chk("lowbits_addr", tr_addr[c0+1], 32'h3000_0014);
        xfer(1'b1, 4'hC, 32'h3000_0008, 32'h5566_7788, 32'd0, 3, c0);
        chk("pw_hi_mem", mem[2], 32'h5566_0002);
        w0 = wr_cnt; a0 = ack_cnt;
        start(1'b1, 4'h3, 32'h3000_000C, 32'hFFFF_FFFF);
        @(negedge clk);
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_mrg_wr", wr_cnt - w0, 32'd0);
        chk("abort_mrg_ack", ack_cnt - a0, 32'd0);
        chk("abort_mrg_mem", mem[3], 32'hA000_0003);
        xfer(1'b1, 4'hF, 32'h3000_000C, 32'hCAFE_F00D, 32'd0, 2, c0);
        chk("after_abort_mem", mem[3], 32'hCAFE_F00D);
        w0 = wr_cnt; a0 = ack_cnt;
        start(1'b1, 4'hF, 32'h3000_0010, 32'h0BAD_F00D);
        @(negedge clk);
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_wr_done", wr_cnt - w0, 32'd1);
        chk("abort_wr_mem", mem[4], 32'h0BAD_F00D);
        chk("abort_wr_ack", ack_cnt - a0, 32'd0);
        w0 = wr_cnt; a0 = ack_cnt;
        start(1'b0, 4'hF, 32'h3000_0014, 32'd0);
        @(negedge clk);
        rst_l = 1'b0;
        #1;
        chk("rstmid_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
        chk("rstmid_addr", reg_addr, IDLE_A);
        chk("rstmid_wren", {31'd0, reg_wren}, 32'd0);
        chk("rstmid_dat", wb.wbs_dat_o, 32'd0);
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("rstmid_noack", ack_cnt - a0, 32'd0);
        chk("rstmid_nowr", wr_cnt - w0, 32'd0);
        xfer(1'b0, 4'hF, 32'h3000_0000, 32'd0, 32'h3F80_0000, 2, c0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
